// File: rtl/frame_uploader_pkg.sv
// Shared definitions for the PSRAM frame-buffer write side: FSM state
// encoding, capture-queue marker words and burst sizing helper.
package frame_uploader_pkg;

  typedef enum logic [2:0] {
    WAIT_FRAME,
    FETCH,
    FETCH_WAIT,
    DECODE,
    WRITE_REQ,
    WRITE_WAIT_ACK,
    WRITE_BURST,
    FRAME_DONE
  } t_state;

  // Capture-queue word format, shared with the display-side downloader.
  localparam logic [16:0] MARK_FRAME_START = 17'h10000;
  localparam logic [16:0] MARK_ROW_START   = 17'h10001;
  localparam logic [16:0] MARK_FRAME_END   = 17'h1FFFF;

  // Number of 32-bit data cycles in one PSRAM burst of the given byte size.
  function automatic int burst_cycles(input int burst_bytes);
    return burst_bytes / 4;
  endfunction

endpackage

// File: rtl/frame_uploader_pixel_cache.sv
// One-burst pixel cache: filled one 16-bit pixel at a time, drained as
// 32-bit words {pixel[2k+1], pixel[2k]} through a registered read port.
module frame_uploader_pixel_cache
  import frame_uploader_pkg::*;
#(
  parameter int CACHE_SIZE  = 16,
  parameter int BURST_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [$clog2(CACHE_SIZE)-1:0]  wr_idx,
  input  logic [15:0]                    wr_pixel,
  input  logic [$clog2(BURST_WORDS)-1:0] rd_idx,
  output logic [31:0]                    rd_word
);

  localparam int CW = $clog2(CACHE_SIZE);

  logic [15:0]   mem [CACHE_SIZE];
  logic [CW-1:0] lo_idx;
  logic [CW-1:0] hi_idx;

  assign lo_idx = {rd_idx, 1'b0};
  assign hi_idx = {rd_idx, 1'b1};

  // Pixel storage, no reset needed: contents are only read after a full fill.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_pixel;
  end

  // Registered word read; cleared on reset so write_data reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_word <= '0;
    else          rd_word <= {mem[hi_idx], mem[lo_idx]};
  end

endmodule

// File: rtl/frame_uploader.sv
// Write side of the PSRAM frame buffer: pops pixels/markers from the capture
// queue, packs them into one-burst caches and writes full bursts through the
// arbiter write port.
//
// state          | meaning
// WAIT_FRAME     | idle; leaves when enable is high
// FETCH          | waiting for a non-empty queue to pop
// FETCH_WAIT     | rd_en high; queue data arrives next cycle
// DECODE         | classify queue word (marker / pixel / junk)
// WRITE_REQ      | cache full; raise write_rq with burst address
// WRITE_WAIT_ACK | hold request, word 0 prefetched from cache
// WRITE_BURST    | stream BURST_WORDS words, mem_wr_en on word 0
// FRAME_DONE     | upload_done (+frame_error) pulse
module frame_uploader
  import frame_uploader_pkg::*;
#(
  parameter int MEMORY_BURST = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [20:0] base_addr,
  input  logic [16:0] queue_data_i,
  input  logic        queue_empty,
  output logic        rd_en,
  output logic        write_rq,
  input  logic        write_ack,
  output logic [20:0] write_addr,
  output logic [31:0] write_data,
  output logic        mem_wr_en,
  output logic        upload_done,
  output logic        frame_error
);

  localparam int BURST_WORDS = burst_cycles(MEMORY_BURST);
  localparam int CACHE_SIZE  = 2 * BURST_WORDS;
  localparam int CW          = $clog2(CACHE_SIZE);
  localparam int BW          = $clog2(BURST_WORDS);

  localparam logic [15:0]   WIDTH_L    = 16'(FRAME_WIDTH);
  localparam logic [15:0]   LAST_ROW   = 16'(FRAME_HEIGHT - 1);
  localparam logic [CW-1:0] CACHE_LAST = CW'(CACHE_SIZE - 1);
  localparam logic [BW-1:0] WORD_LAST  = BW'(BURST_WORDS - 1);
  localparam logic [20:0]   ADDR_STEP  = 21'(CACHE_SIZE);

  // Rows must be made of whole bursts so every row starts burst-aligned.
  if (FRAME_WIDTH % CACHE_SIZE != 0) begin : g_width_check
    $error("frame_uploader: FRAME_WIDTH must be a multiple of the cache size");
  end

  t_state        state;
  logic [15:0]   row_cnt;
  logic [15:0]   col_cnt;
  logic [CW-1:0] cache_idx;
  logic [BW-1:0] burst_idx;
  logic [20:0]   addr_cnt;
  logic          err;
  logic          in_frame;
  logic          seen_row;
  logic          restart;

  logic          is_pixel;
  logic          pix_ok;
  logic          end_err;
  logic          cache_we;
  logic [BW-1:0] cache_rd_idx;

  assign is_pixel = ~queue_data_i[16];
  assign pix_ok   = in_frame && seen_row && (col_cnt != WIDTH_L);
  assign end_err  = err || !seen_row || (row_cnt != LAST_ROW) ||
                    (col_cnt != WIDTH_L) || (cache_idx != '0);
  assign cache_we = (state == DECODE) && is_pixel && pix_ok;

  // Word 0 is read while waiting for the grant so it is ready on the first burst cycle.
  assign cache_rd_idx = (state == WRITE_BURST) ? BW'(burst_idx + 1'b1) : '0;

  frame_uploader_pixel_cache #(
    .CACHE_SIZE  (CACHE_SIZE),
    .BURST_WORDS (BURST_WORDS)
  ) u_cache (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (cache_we),
    .wr_idx   (cache_idx),
    .wr_pixel (queue_data_i[15:0]),
    .rd_idx   (cache_rd_idx),
    .rd_word  (write_data)
  );

  // Sequencer: queue popping, marker/pixel decode, burst handshake, frame status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_FRAME;
      row_cnt     <= '0;
      col_cnt     <= '0;
      cache_idx   <= '0;
      burst_idx   <= '0;
      addr_cnt    <= '0;
      err         <= 1'b0;
      in_frame    <= 1'b0;
      seen_row    <= 1'b0;
      restart     <= 1'b0;
      rd_en       <= 1'b0;
      write_rq    <= 1'b0;
      write_addr  <= '0;
      mem_wr_en   <= 1'b0;
      upload_done <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rd_en       <= 1'b0;
      mem_wr_en   <= 1'b0;
      upload_done <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (enable) begin
            in_frame <= 1'b0;
            rd_en    <= !queue_empty;
            state    <= queue_empty ? FETCH : FETCH_WAIT;
          end
        end
        FETCH: begin
          if (!queue_empty) begin
            rd_en <= 1'b1;
            state <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: state <= DECODE;
        DECODE: begin
          // Default: keep streaming, popping back-to-back when data is waiting.
          rd_en <= !queue_empty;
          state <= queue_empty ? FETCH : FETCH_WAIT;
          if (!in_frame) begin
            if (queue_data_i == MARK_FRAME_START) begin
              addr_cnt  <= base_addr;
              row_cnt   <= '0;
              col_cnt   <= '0;
              cache_idx <= '0;
              err       <= 1'b0;
              seen_row  <= 1'b0;
              in_frame  <= 1'b1;
            end
          end else if (queue_data_i == MARK_FRAME_START) begin
            // Unexpected restart: close this frame as bad, reopen in FRAME_DONE.
            upload_done <= 1'b1;
            frame_error <= 1'b1;
            in_frame    <= 1'b0;
            restart     <= 1'b1;
            rd_en       <= 1'b0;
            state       <= FRAME_DONE;
          end else if (queue_data_i == MARK_ROW_START) begin
            if (seen_row) begin
              row_cnt <= row_cnt + 16'd1;
              if ((cache_idx != '0) || (col_cnt != WIDTH_L)) err <= 1'b1;
            end
            seen_row  <= 1'b1;
            col_cnt   <= '0;
            cache_idx <= '0;
          end else if (queue_data_i == MARK_FRAME_END) begin
            upload_done <= 1'b1;
            frame_error <= end_err;
            in_frame    <= 1'b0;
            rd_en       <= 1'b0;
            state       <= FRAME_DONE;
          end else if (is_pixel) begin
            if (pix_ok) begin
              col_cnt <= col_cnt + 16'd1;
              if (cache_idx == CACHE_LAST) begin
                rd_en <= 1'b0;
                state <= WRITE_REQ;
              end else begin
                cache_idx <= cache_idx + CW'(1);
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE_REQ: begin
          write_rq   <= 1'b1;
          write_addr <= addr_cnt;
          state      <= WRITE_WAIT_ACK;
        end
        WRITE_WAIT_ACK: begin
          if (write_ack) begin
            mem_wr_en <= 1'b1;
            burst_idx <= '0;
            state     <= WRITE_BURST;
          end
        end
        WRITE_BURST: begin
          if (burst_idx == WORD_LAST) begin
            write_rq  <= 1'b0;
            addr_cnt  <= addr_cnt + ADDR_STEP;
            cache_idx <= '0;
            state     <= FETCH;
          end else begin
            burst_idx <= burst_idx + BW'(1);
          end
        end
        FRAME_DONE: begin
          if (restart) begin
            restart   <= 1'b0;
            addr_cnt  <= base_addr;
            row_cnt   <= '0;
            col_cnt   <= '0;
            cache_idx <= '0;
            err       <= 1'b0;
            seen_row  <= 1'b0;
            in_frame  <= 1'b1;
            state     <= FETCH;
          end else begin
            state <= WAIT_FRAME;
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule
